// File: rtl/obj_layer_reader.sv
// obj_layer_reader: object table, per-line scan buffer and per-pixel object lookup
//
// Holds the 8-entry object table written by the game controller. On every
// iLineStart the table is scanned, one entry per cycle, into a per-line slot
// buffer. After that, active-video pixels are looked up against the buffer.
// Each entry is {ON, TILE[2:0], X[4:0], Y[3:0]}.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   iObjRam_addr/data/we   object table write port
//   iFrameStart            start of vertical blank, abandons any scan
//   iLineStart             start of h-blank, iPixY holds the next displayed line
//   iPixValid, iPixX/Y     pixel being displayed
//   oScanBusy              line scan in progress
//   oObj_hit/tile/u/v      registered lookup result for last cycle's pixel
//   oOverlap               sticky multi-object flag, only with OBJ_OVERLAP_EN
//
// Build option: define OBJ_OVERLAP_EN to add oOverlap.
module obj_layer_reader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  iObjRam_addr,
    input  logic [12:0] iObjRam_data,
    input  logic        iObjRam_we,
    input  logic        iFrameStart,
    input  logic        iLineStart,
    input  logic        iPixValid,
    input  logic [9:0]  iPixX,
    input  logic [9:0]  iPixY,
    output logic        oScanBusy,
    output logic        oObj_hit,
    output logic [2:0]  oObj_tile,
    output logic [4:0]  oObj_u,
    output logic [4:0]  oObj_v
`ifdef OBJ_OVERLAP_EN
    ,
    output logic        oOverlap
`endif
);
    localparam int N_OBJ      = 8;
    localparam int TILE_SHIFT = 5;

    typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

    state_t                r_state, w_next;
    logic [N_OBJ-1:0][12:0] r_mem;
    logic [N_OBJ-1:0]       r_valid;
    logic [N_OBJ-1:0][2:0]  r_tile;
    logic [N_OBJ-1:0][4:0]  r_x;
    logic [4:0]             r_row;
    logic [2:0]             r_idx;
    logic [4:0]             w_col;
    logic [N_OBJ-1:0]       w_match;
    logic [2:0]             w_tile;
    logic                   w_hit;
    logic [12:0]            w_entry;

    assign oScanBusy = (r_state == SCAN);
    assign w_col     = iPixX[9:TILE_SHIFT];
    assign w_entry   = r_mem[r_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (iFrameStart)
            w_next = IDLE;
        else if (iLineStart)
            w_next = SCAN;
        else if (r_state == SCAN && r_idx == 3'd7)
            w_next = READY;
    end

    // Lowest matching index wins, so walk downwards and let it overwrite.
    always_comb begin
        w_match = '0;
        w_tile  = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            w_match[i] = r_valid[i] && (r_x[i] == w_col);
            if (w_match[i])
                w_tile = r_tile[i];
        end
        w_hit = iPixValid && (r_state == READY) && (|w_match);
    end

    // The scan reads the table before this edge's write lands, so a write to
    // the entry being scanned (or an earlier one) only shows on the next line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem     <= '0;
            r_valid   <= '0;
            r_tile    <= '0;
            r_x       <= '0;
            r_row     <= '0;
            r_idx     <= '0;
            oObj_hit  <= 1'b0;
            oObj_tile <= '0;
            oObj_u    <= '0;
            oObj_v    <= '0;
        end else begin
            if (iObjRam_we)
                r_mem[iObjRam_addr] <= iObjRam_data;
            if (iFrameStart) begin
                r_valid <= '0;
            end else if (iLineStart) begin
                r_row   <= iPixY[9:TILE_SHIFT];
                r_idx   <= '0;
                r_valid <= '0;
            end else if (r_state == SCAN) begin
                r_valid[r_idx] <= w_entry[12] && ({1'b0, w_entry[3:0]} == r_row);
                r_tile[r_idx]  <= w_entry[11:9];
                r_x[r_idx]     <= w_entry[8:4];
                r_idx          <= r_idx + 3'd1;
            end
            oObj_hit  <= w_hit;
            oObj_tile <= w_hit ? w_tile : 3'd0;
            oObj_u    <= w_hit ? iPixX[4:0] : 5'd0;
            oObj_v    <= w_hit ? iPixY[4:0] : 5'd0;
        end
    end

`ifdef OBJ_OVERLAP_EN
    logic w_multi;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(w_match & (w_match - 8'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            oOverlap <= 1'b0;
        else if (iFrameStart)
            oOverlap <= 1'b0;
        else if (iPixValid && r_state == READY && w_multi)
            oOverlap <= 1'b1;
    end
`endif

endmodule
